ff_bank_ctrl: RTL and testbench
===============================

FF_BANK_CTRL -- requirements
Module: ff_bank_ctrl

Interface
REQ-001 Parameter NREG, default 8, number of register slots in the controlled bank (2..64).
REQ-002 Parameter WIDTH, default 8, data width of each slot.
REQ-003 Parameter AW, default $clog2(NREG), slot address width.
REQ-004 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-005 LSR  in  1  reset, asynchronous, active-high.
REQ-006 a_valid/b_valid  in  1  requester A/B command valid.
REQ-007 a_ready/b_ready  out  1  requester A/B command accepted this cycle.
REQ-008 a_clr/b_clr  in  1  command type: 1 = clear slot, 0 = write slot.
REQ-009 a_addr/b_addr  in  AW  target slot.
REQ-010 a_data/b_data  in  WIDTH  write data; ignored for clear.
REQ-011 sweep_req  in  1  single-cycle request to re-clear the whole bank.
REQ-012 slot_lsr  out  NREG  per-slot synchronous set/reset strobe to the bank cells.
REQ-013 slot_we  out  NREG  per-slot write strobe selecting slot_di onto the cell DI.
REQ-014 slot_di  out  WIDTH  shared write data to the bank.
REQ-015 init_done  out  1  high when no sweep is in progress.
REQ-016 addr_err  out  1  one-cycle pulse: accepted command had addr >= NREG.

Function
REQ-017 FSM states SHALL be SWEEP and SERVE; reset enters SWEEP with sweep index 0.
REQ-018 In SWEEP, slot_lsr SHALL be one-hot at the sweep index for exactly one cycle per index, from 0 to NREG-1, ascending.
REQ-019 After index NREG-1, the next cycle SHALL be SERVE with init_done=1; a full sweep lasts NREG cycles.
REQ-020 In SWEEP, a_ready, b_ready and slot_we SHALL be 0; sweep_req SHALL be ignored.
REQ-021 In SERVE, sweep_req=1 SHALL enter SWEEP at index 0 next cycle and take precedence over any same-cycle command; no ready is asserted that cycle.
REQ-022 In SERVE, at most one requester SHALL be granted per cycle; x_ready is combinational from x_valid, the state and the round-robin pointer.
REQ-023 Arbitration SHALL be round-robin: when both are valid, grant the requester not granted most recently; after reset, A wins the first tie.
REQ-024 A lone valid requester SHALL be granted in the same cycle (no bubble); back-to-back grants every cycle SHALL be supported.
REQ-025 A command accepted at edge k SHALL drive the registered outputs during cycle k+1 only: write asserts slot_we[addr] with slot_di=data; clear asserts slot_lsr[addr].
REQ-026 slot_we and slot_lsr SHALL never both be asserted for the same slot, and each SHALL be at most one-hot.
REQ-027 An accepted command with addr >= NREG SHALL assert no strobe and SHALL pulse addr_err in cycle k+1.
REQ-028 Requesters SHALL hold valid, clr, addr and data stable until ready; the controller SHALL NOT require valid to drop after acceptance.
REQ-029 slot_di SHALL hold its last value when no write is issued.

Reset
REQ-030 While LSR=1: state=SWEEP, index=0, RR pointer favours A, slot_we=0, slot_lsr=0, slot_di=0, addr_err=0, init_done=0, a_ready=b_ready=0.
REQ-031 Assertion of LSR mid-sweep or mid-command SHALL abort the operation immediately; the sweep SHALL restart at index 0 on the first edge after release.

Structure
REQ-032 The shared package SHALL hold the state enum (SWEEP, SERVE) and the command-type constants (CMD_WRITE=0, CMD_CLEAR=1).
REQ-033 The two-requester round-robin arbiter SHALL be a sub-module named ff_bank_rr_arb; the sweep FSM and strobe decode stay in ff_bank_ctrl.

Verification
REQ-034 Reset release, no requests, NREG=8 -> slot_lsr = 0x01,0x02,...,0x80 on 8 consecutive cycles, then init_done=1.
REQ-035 SERVE, A write addr=3 data=0xA5 alone -> a_ready same cycle; next cycle slot_we=0x08, slot_di=0xA5, slot_lsr=0.
REQ-036 Both valid for 4 cycles (A write addr 1, B clear addr 2) -> grants A,B,A,B; strobes slot_we=0x02, slot_lsr=0x04 alternating.
REQ-037 NREG=6, B write addr=7 -> b_ready, addr_err pulses once, slot_we=slot_lsr=0.
REQ-038 sweep_req with A valid in same cycle -> a_ready=0, sweep of NREG cycles, then A granted on first SERVE cycle.
REQ-039 LSR pulsed at sweep index 4 -> all outputs zero during reset; sweep restarts at index 0 after release.

Source files
------------

// File: rtl/ff_bank_pkg.sv
// Shared types and constants for the register-bank controller and its arbiter.
// The controller either sweeps (re-clears) the bank or serves requester commands.
package ff_bank_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_CLEAR = 1'b1;

endpackage

// File: rtl/ff_bank_rr_arb.sv
// Two-requester round-robin arbiter. Grants combinationally and hands priority to
// the requester that was not granted most recently; A wins the first tie after reset.
module ff_bank_rr_arb (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic a_valid,
    input  logic b_valid,
    output logic a_grant,
    output logic b_grant
);

    logic prio_b_reg;

    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (enable) begin
            if (a_valid && b_valid) begin
                a_grant = ~prio_b_reg;
                b_grant = prio_b_reg;
            end else begin
                a_grant = a_valid;
                b_grant = b_valid;
            end
        end
    end

    // Lone grants also count as "most recent", so the pointer moves on any grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_b_reg <= 1'b0;
        end else if (a_grant) begin
            prio_b_reg <= 1'b1;
        end else if (b_grant) begin
            prio_b_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/ff_bank_ctrl.sv
// Controller for a bank of NREG register slots: sweeps a clear strobe across every
// slot after reset or on request, then serves write/clear commands from two requesters.
module ff_bank_ctrl
    import ff_bank_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(NREG)
) (
    input  logic             CLK,
    input  logic             LSR,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic             a_clr,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic             b_clr,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_data,
    input  logic             sweep_req,
    output logic [NREG-1:0]  slot_lsr,
    output logic [NREG-1:0]  slot_we,
    output logic [WIDTH-1:0] slot_di,
    output logic             init_done,
    output logic             addr_err
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam logic [AW:0]   NREG_EXT = (AW + 1)'(NREG);

    state_t           state_reg, state_next;
    logic [AW-1:0]    idx_reg, idx_next;
    logic [NREG-1:0]  slot_lsr_reg, slot_lsr_next;
    logic [NREG-1:0]  slot_we_reg, slot_we_next;
    logic [WIDTH-1:0] slot_di_reg, slot_di_next;
    logic             addr_err_reg, addr_err_next;

    logic             arb_enable;
    logic             a_grant, b_grant;
    logic             cmd_valid;
    logic             cmd_clr;
    logic [AW-1:0]    cmd_addr;
    logic [WIDTH-1:0] cmd_data;
    logic             addr_ok;
    logic [NREG-1:0]  sel_onehot;
    logic [NREG-1:0]  sweep_onehot;

    // A sweep request wins over any same-cycle command, so nobody is granted then.
    assign arb_enable = (state_reg == SERVE) && !sweep_req;

    ff_bank_rr_arb u_arb (
        .clk     (CLK),
        .rst     (LSR),
        .enable  (arb_enable),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .a_grant (a_grant),
        .b_grant (b_grant)
    );

    assign a_ready   = a_grant;
    assign b_ready   = b_grant;
    assign cmd_valid = a_grant | b_grant;
    assign cmd_clr   = a_grant ? a_clr  : b_clr;
    assign cmd_addr  = a_grant ? a_addr : b_addr;
    assign cmd_data  = a_grant ? a_data : b_data;
    assign addr_ok   = {1'b0, cmd_addr} < NREG_EXT;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_decode
            assign sel_onehot[gi]   = (cmd_addr == AW'(gi));
            assign sweep_onehot[gi] = (idx_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge CLK or posedge LSR) begin
        if (LSR) begin
            state_reg    <= SWEEP;
            idx_reg      <= '0;
            slot_lsr_reg <= '0;
            slot_we_reg  <= '0;
            slot_di_reg  <= '0;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            slot_lsr_reg <= slot_lsr_next;
            slot_we_reg  <= slot_we_next;
            slot_di_reg  <= slot_di_next;
            addr_err_reg <= addr_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        slot_lsr_next = '0;
        slot_we_next  = '0;
        slot_di_next  = slot_di_reg;
        addr_err_next = 1'b0;
        case (state_reg)
            SWEEP: begin
                slot_lsr_next = sweep_onehot;
                if (idx_reg == LAST_IDX) begin
                    state_next = SERVE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + AW'(1);
                end
            end
            SERVE: begin
                if (sweep_req) begin
                    state_next = SWEEP;
                    idx_next   = '0;
                end else if (cmd_valid) begin
                    // Out-of-range commands are consumed but only flag an error.
                    if (!addr_ok) begin
                        addr_err_next = 1'b1;
                    end else if (cmd_clr == CMD_CLEAR) begin
                        slot_lsr_next = sel_onehot;
                    end else begin
                        slot_we_next = sel_onehot;
                        slot_di_next = cmd_data;
                    end
                end
            end
            default: begin
                state_next = SWEEP;
                idx_next   = '0;
            end
        endcase
    end

    assign slot_lsr  = slot_lsr_reg;
    assign slot_we   = slot_we_reg;
    assign slot_di   = slot_di_reg;
    assign addr_err  = addr_err_reg;
    assign init_done = (state_reg == SERVE);

endmodule

// File: tb/tb_ff_bank_ctrl.sv
// Directed bench for ff_bank_ctrl: an NREG=8 instance for sweep, arbitration and
// strobes, plus an NREG=6 instance for out-of-range addresses.
module tb_ff_bank_ctrl;

    logic       CLK = 1'b0;
    logic       LSR;
    logic       a_valid, a_clr, b_valid, b_clr, sweep_req;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, init_done, addr_err;
    logic [7:0] slot_lsr, slot_we, slot_di;

    logic       a6_valid, a6_clr, b6_valid, b6_clr, sweep_req6;
    logic [2:0] a6_addr, b6_addr;
    logic [7:0] a6_data, b6_data;
    logic       a6_ready, b6_ready, init_done6, addr_err6;
    logic [5:0] slot_lsr6, slot_we6;
    logic [7:0] slot_di6;

    int checks = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    ff_bank_ctrl #(.NREG(8), .WIDTH(8)) dut (
        .CLK(CLK), .LSR(LSR),
        .a_valid(a_valid), .a_ready(a_ready), .a_clr(a_clr), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_clr(b_clr), .b_addr(b_addr), .b_data(b_data),
        .sweep_req(sweep_req), .slot_lsr(slot_lsr), .slot_we(slot_we), .slot_di(slot_di),
        .init_done(init_done), .addr_err(addr_err)
    );

    ff_bank_ctrl #(.NREG(6), .WIDTH(8)) dut6 (
        .CLK(CLK), .LSR(LSR),
        .a_valid(a6_valid), .a_ready(a6_ready), .a_clr(a6_clr), .a_addr(a6_addr), .a_data(a6_data),
        .b_valid(b6_valid), .b_ready(b6_ready), .b_clr(b6_clr), .b_addr(b6_addr), .b_data(b6_data),
        .sweep_req(sweep_req6), .slot_lsr(slot_lsr6), .slot_we(slot_we6), .slot_di(slot_di6),
        .init_done(init_done6), .addr_err(addr_err6)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        LSR = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        repeat (2) step();
        checks++; if (slot_lsr !== 8'h00) $display("FAIL reset_lsr: got %h expected 00", slot_lsr); else passed++;
        checks++; if (slot_we !== 8'h00) $display("FAIL reset_we: got %h expected 00", slot_we); else passed++;
        checks++; if (slot_di !== 8'h00) $display("FAIL reset_di: got %h expected 00", slot_di); else passed++;
        checks++; if (addr_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", addr_err); else passed++;
        checks++; if (init_done !== 1'b0) $display("FAIL reset_init: got %b expected 0", init_done); else passed++;
        checks++; if ({a_ready, b_ready} !== 2'b00) $display("FAIL reset_ready: got %b expected 00", {a_ready, b_ready}); else passed++;
        checks++; if (init_done6 !== 1'b0) $display("FAIL reset_init6: got %b expected 0", init_done6); else passed++;
        $display("reset: lsr=%h we=%h init=%b", slot_lsr, slot_we, init_done);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_sweep();
        logic [7:0] exp_lsr;
        LSR = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_lsr = 8'h01 << i;
            $display("sweep %0d: lsr=%h init=%b", i, slot_lsr, init_done);
            checks++; if (slot_lsr !== exp_lsr) $display("FAIL sweep_lsr: got %h expected %h", slot_lsr, exp_lsr); else passed++;
            checks++; if (slot_we !== 8'h00) $display("FAIL sweep_we: got %h expected 00", slot_we); else passed++;
            if (i < 7) begin
                checks++; if (init_done !== 1'b0) $display("FAIL sweep_init: got %b expected 0", init_done); else passed++;
            end
        end
        step();
        checks++; if (init_done !== 1'b1) $display("FAIL sweep_done: got %b expected 1", init_done); else passed++;
        checks++; if (slot_lsr !== 8'h00) $display("FAIL sweep_end_lsr: got %h expected 00", slot_lsr); else passed++;
    endtask

    task automatic test_write_alone();
        a_valid = 1'b1; a_clr = 1'b0; a_addr = 3'd3; a_data = 8'hA5;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b10) $display("FAIL wr_ready: got %b expected 10", {a_ready, b_ready}); else passed++;
        step();
        a_valid = 1'b0;
        $display("write A addr=3: we=%h di=%h lsr=%h", slot_we, slot_di, slot_lsr);
        checks++; if (slot_we !== 8'h08) $display("FAIL wr_we: got %h expected 08", slot_we); else passed++;
        checks++; if (slot_di !== 8'hA5) $display("FAIL wr_di: got %h expected a5", slot_di); else passed++;
        checks++; if (slot_lsr !== 8'h00) $display("FAIL wr_lsr: got %h expected 00", slot_lsr); else passed++;
        checks++; if (addr_err !== 1'b0) $display("FAIL wr_err: got %b expected 0", addr_err); else passed++;
        step();
        checks++; if (slot_we !== 8'h00) $display("FAIL wr_we_drop: got %h expected 00", slot_we); else passed++;
        checks++; if (slot_di !== 8'hA5) $display("FAIL wr_di_hold: got %h expected a5", slot_di); else passed++;
    endtask

    task automatic test_clear_b();
        b_valid = 1'b1; b_clr = 1'b1; b_addr = 3'd5; b_data = 8'hFF;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b01) $display("FAIL clr_ready: got %b expected 01", {a_ready, b_ready}); else passed++;
        step();
        b_valid = 1'b0;
        $display("clear B addr=5: lsr=%h we=%h", slot_lsr, slot_we);
        checks++; if (slot_lsr !== 8'h20) $display("FAIL clr_lsr: got %h expected 20", slot_lsr); else passed++;
        checks++; if (slot_we !== 8'h00) $display("FAIL clr_we: got %h expected 00", slot_we); else passed++;
        checks++; if (slot_di !== 8'hA5) $display("FAIL clr_di_hold: got %h expected a5", slot_di); else passed++;
    endtask

    task automatic test_back_to_back();
        logic       exp_a;
        logic [7:0] exp_we, exp_lsr;
        a_valid = 1'b1; a_clr = 1'b0; a_addr = 3'd1; a_data = 8'h11;
        b_valid = 1'b1; b_clr = 1'b1; b_addr = 3'd2; b_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_a   = (i % 2 == 0);
            exp_we  = exp_a ? 8'h02 : 8'h00;
            exp_lsr = exp_a ? 8'h00 : 8'h04;
            checks++; if ({a_ready, b_ready} !== {exp_a, ~exp_a}) $display("FAIL rr_grant%0d: got %b expected %b", i, {a_ready, b_ready}, {exp_a, ~exp_a}); else passed++;
            step();
            $display("rr %0d: we=%h lsr=%h", i, slot_we, slot_lsr);
            checks++; if (slot_we !== exp_we) $display("FAIL rr_we%0d: got %h expected %h", i, slot_we, exp_we); else passed++;
            checks++; if (slot_lsr !== exp_lsr) $display("FAIL rr_lsr%0d: got %h expected %h", i, slot_lsr, exp_lsr); else passed++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        checks++; if (slot_di !== 8'h11) $display("FAIL rr_di: got %h expected 11", slot_di); else passed++;
    endtask

    task automatic test_addr_err();
        b6_valid = 1'b1; b6_clr = 1'b0; b6_addr = 3'd7; b6_data = 8'h3C;
        #1;
        checks++; if (b6_ready !== 1'b1) $display("FAIL err_ready: got %b expected 1", b6_ready); else passed++;
        step();
        b6_valid = 1'b0;
        $display("B addr=7 on NREG=6: err=%b we=%h lsr=%h", addr_err6, slot_we6, slot_lsr6);
        checks++; if (addr_err6 !== 1'b1) $display("FAIL err_pulse: got %b expected 1", addr_err6); else passed++;
        checks++; if (slot_we6 !== 6'h00) $display("FAIL err_we: got %h expected 00", slot_we6); else passed++;
        checks++; if (slot_lsr6 !== 6'h00) $display("FAIL err_lsr: got %h expected 00", slot_lsr6); else passed++;
        step();
        checks++; if (addr_err6 !== 1'b0) $display("FAIL err_once: got %b expected 0", addr_err6); else passed++;
    endtask

    task automatic test_sweep_req();
        logic [7:0] exp_lsr;
        sweep_req = 1'b1;
        a_valid = 1'b1; a_clr = 1'b0; a_addr = 3'd6; a_data = 8'h5A;
        #1;
        checks++; if (a_ready !== 1'b0) $display("FAIL swr_ready: got %b expected 0", a_ready); else passed++;
        step();
        sweep_req = 1'b0;
        #1;
        checks++; if (init_done !== 1'b0) $display("FAIL swr_init: got %b expected 0", init_done); else passed++;
        checks++; if ({slot_lsr, slot_we} !== 16'h0000) $display("FAIL swr_idle: got %h expected 0000", {slot_lsr, slot_we}); else passed++;
        checks++; if (a_ready !== 1'b0) $display("FAIL swr_ready_sweep: got %b expected 0", a_ready); else passed++;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_lsr = 8'h01 << i;
            $display("sweep_req %0d: lsr=%h a_ready=%b", i, slot_lsr, a_ready);
            checks++; if (slot_lsr !== exp_lsr) $display("FAIL swr_lsr: got %h expected %h", slot_lsr, exp_lsr); else passed++;
            checks++; if (a_ready !== (i == 7)) $display("FAIL swr_grant%0d: got %b expected %b", i, a_ready, (i == 7)); else passed++;
        end
        step();
        a_valid = 1'b0;
        checks++; if (slot_we !== 8'h40) $display("FAIL swr_we: got %h expected 40", slot_we); else passed++;
        checks++; if (slot_di !== 8'h5A) $display("FAIL swr_di: got %h expected 5a", slot_di); else passed++;
    endtask

    task automatic test_reset_abort();
        logic [7:0] exp_lsr;
        sweep_req = 1'b1;
        step();
        sweep_req = 1'b0;
        repeat (4) step();
        checks++; if (slot_lsr !== 8'h08) $display("FAIL abort_pre: got %h expected 08", slot_lsr); else passed++;
        a_valid = 1'b1; a_clr = 1'b0; a_addr = 3'd0;
        LSR = 1'b1;
        #1;
        $display("abort at index 4: lsr=%h we=%h di=%h", slot_lsr, slot_we, slot_di);
        checks++; if ({slot_lsr, slot_we, slot_di} !== 24'h0) $display("FAIL abort_out: got %h expected 000000", {slot_lsr, slot_we, slot_di}); else passed++;
        checks++; if ({addr_err, init_done, a_ready, b_ready} !== 4'b0) $display("FAIL abort_flags: got %b expected 0000", {addr_err, init_done, a_ready, b_ready}); else passed++;
        step();
        checks++; if (slot_lsr !== 8'h00) $display("FAIL abort_hold: got %h expected 00", slot_lsr); else passed++;
        LSR = 1'b0;
        a_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_lsr = 8'h01 << i;
            checks++; if (slot_lsr !== exp_lsr) $display("FAIL abort_lsr%0d: got %h expected %h", i, slot_lsr, exp_lsr); else passed++;
        end
        step();
        checks++; if (init_done !== 1'b1) $display("FAIL abort_done: got %b expected 1", init_done); else passed++;
    endtask

    task automatic test_tie_after_reset();
        a_valid = 1'b1; a_clr = 1'b1; a_addr = 3'd0;
        b_valid = 1'b1; b_clr = 1'b0; b_addr = 3'd4; b_data = 8'h77;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b10) $display("FAIL tie_first: got %b expected 10", {a_ready, b_ready}); else passed++;
        step();
        checks++; if (slot_lsr !== 8'h01) $display("FAIL tie_lsr: got %h expected 01", slot_lsr); else passed++;
        checks++; if ({a_ready, b_ready} !== 2'b01) $display("FAIL tie_second: got %b expected 01", {a_ready, b_ready}); else passed++;
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
        $display("tie after reset: we=%h di=%h", slot_we, slot_di);
        checks++; if (slot_we !== 8'h10) $display("FAIL tie_we: got %h expected 10", slot_we); else passed++;
        checks++; if (slot_di !== 8'h77) $display("FAIL tie_di: got %h expected 77", slot_di); else passed++;
    endtask

    initial begin
        LSR = 1'b1;
        a_valid = 1'b0; a_clr = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_clr = 1'b0; b_addr = '0; b_data = '0;
        sweep_req = 1'b0;
        a6_valid = 1'b0; a6_clr = 1'b0; a6_addr = '0; a6_data = '0;
        b6_valid = 1'b0; b6_clr = 1'b0; b6_addr = '0; b6_data = '0;
        sweep_req6 = 1'b0;
        test_reset();
        test_sweep();
        test_write_alone();
        test_clear_b();
        test_back_to_back();
        test_addr_err();
        test_sweep_req();
        test_reset_abort();
        test_tie_after_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
